// File: rtl/cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator.
// FSM states, decision codes and verdict legality.
package cmp_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    D_UND = 2'd0,
    D_GT  = 2'd1,
    D_LT  = 2'd2
  } dec_e;

  // A verdict is legal when exactly one of the three flags is high.
  function automatic logic verdict_legal(
    input logic asb,
    input logic aib,
    input logic aeb
  );
    return (asb ^ aib ^ aeb) && !(asb && aib && aeb);
  endfunction

endpackage

// File: rtl/cmp_bit_decode.sv
// Per-beat verdict decoder for the serial comparator.
// Maps one bit-pair verdict to a decision step plus legality.
module cmp_bit_decode
  import cmp_pkg::*;
(
  input  logic i_asb,
  input  logic i_aib,
  input  logic i_aeb,
  output dec_e o_step,
  output logic o_legal
);

  logic w_legal;

  assign w_legal = verdict_legal(i_asb, i_aib, i_aeb);
  assign o_legal = w_legal;

  // Illegal codes fall back to "equal" so they never decide a word.
  always_comb begin
    o_step = D_UND;
    if (w_legal) begin
      unique case (1'b1)
        i_asb:   o_step = D_GT;
        i_aib:   o_step = D_LT;
        default: o_step = D_UND;
      endcase
    end
  end

endmodule

// File: rtl/serial_mag_compare.sv
// Bit-serial N-bit magnitude comparator, MSB first.
// First unequal bit decides; result via valid/ready.
module serial_mag_compare
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic AsB,
  input  logic AiB,
  input  logic AeB,
  output logic res_valid,
  input  logic res_ready,
  output logic a_gt_b,
  output logic a_lt_b,
  output logic a_eq_b,
  output logic code_err,
  output logic busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  state_e          r_state;
  state_e          w_state_n;
  dec_e            r_dec;
  dec_e            w_dec_n;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_n;
  logic            r_err;
  logic            w_err_n;
  dec_e            w_step;
  logic            w_legal;
  logic            w_in_ready;
  logic            w_beat;
  logic            w_done_n;

  cmp_bit_decode u_dec (
    .i_asb   (AsB),
    .i_aib   (AiB),
    .i_aeb   (AeB),
    .o_step  (w_step),
    .o_legal (w_legal)
  );

  assign w_in_ready = rst_n && (r_state != S_DONE);
  assign in_ready   = w_in_ready;
  assign w_beat     = in_valid && w_in_ready;
  assign code_err   = r_err;
  assign w_done_n   = (w_state_n == S_DONE);

  // Next-state, counter, decision and sticky error logic.
  always_comb begin
    w_state_n = r_state;
    w_dec_n   = r_dec;
    w_cnt_n   = r_cnt;
    w_err_n   = r_err;
    unique case (r_state)
      S_IDLE: begin
        if (w_beat) begin
          w_state_n = S_COMPARE;
          w_cnt_n   = LAST;
          w_dec_n   = w_step;
          w_err_n   = !w_legal;
        end
      end
      S_COMPARE: begin
        if (w_beat) begin
          if (r_dec == D_UND) begin
            w_dec_n = w_step;
          end
          w_err_n = r_err || !w_legal;
          if (r_cnt == ONE) begin
            w_state_n = S_DONE;
            w_cnt_n   = '0;
          end else begin
            w_cnt_n = r_cnt - ONE;
          end
        end
      end
      S_DONE: begin
        if (res_ready) begin
          w_state_n = S_IDLE;
          w_dec_n   = D_UND;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_dec_n   = D_UND;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Datapath registers: counter, decision, error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dec <= D_UND;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_dec <= w_dec_n;
      r_cnt <= w_cnt_n;
      r_err <= w_err_n;
    end
  end

  // Registered result and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      a_gt_b    <= 1'b0;
      a_lt_b    <= 1'b0;
      a_eq_b    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      res_valid <= w_done_n;
      a_gt_b    <= w_done_n && (w_dec_n == D_GT);
      a_lt_b    <= w_done_n && (w_dec_n == D_LT);
      a_eq_b    <= w_done_n && (w_dec_n == D_UND);
      busy      <= (w_state_n == S_COMPARE);
    end
  end

endmodule

// File: tb/tb_serial_mag_compare.sv
// Directed bench for serial_mag_compare (WIDTH=8).
// Each task drives one scenario and checks inline.
module tb_serial_mag_compare;

  logic clk;
  logic rst_n;
  logic in_valid;
  logic in_ready;
  logic AsB;
  logic AiB;
  logic AeB;
  logic res_valid;
  logic res_ready;
  logic a_gt_b;
  logic a_lt_b;
  logic a_eq_b;
  logic code_err;
  logic busy;

  int n_chk;
  int n_fail;

  // {in_ready,busy,res_valid,gt,lt,eq,err}
  logic [6:0] obs;
  assign obs = {in_ready, busy, res_valid,
                a_gt_b, a_lt_b, a_eq_b, code_err};

  serial_mag_compare #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .AsB       (AsB),
    .AiB       (AiB),
    .AeB       (AeB),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .a_gt_b    (a_gt_b),
    .a_lt_b    (a_lt_b),
    .a_eq_b    (a_eq_b),
    .code_err  (code_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send bits hi..lo of a/b as verdict beats, MSB first.
  // bad: bit index sent as illegal code; gap: idle cycle before it.
  task automatic run_bits(input logic [7:0] a, input logic [7:0] b,
                          input int hi, input int lo,
                          input int bad, input int gap);
    for (int i = hi; i >= lo; i--) begin
      if (i == gap) begin
        in_valid = 1'b0;
        AsB = 1'b1;
        AiB = 1'b1;
        AeB = 1'b1;
        tick();
      end
      in_valid = 1'b1;
      AsB = a[i] & ~b[i];
      AiB = ~a[i] & b[i];
      AeB = ~(a[i] ^ b[i]);
      if (i == bad) begin
        AsB = 1'b1;
        AiB = 1'b1;
        AeB = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    AsB = 1'b0;
    AiB = 1'b0;
    AeB = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_chk++;
    if (obs !== 7'b0000000) begin
      n_fail++;
      $display("FAIL reset_hold: got %b want %b", obs, 7'b0000000);
    end
    rst_n = 1'b1;
    #1;
    n_chk++;
    if (obs !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_release: got %b want %b", obs, 7'b1000000);
    end
    tick();
  endtask

  task automatic test_gt();
    res_ready = 1'b1;
    run_bits(8'hA5, 8'hA4, 7, 1, -1, -1);
    n_chk++;
    if (obs !== 7'b1100000) begin
      n_fail++;
      $display("FAIL gt_seven_beats: got %b want %b", obs, 7'b1100000);
    end
    run_bits(8'hA5, 8'hA4, 0, 0, -1, -1);
    n_chk++;
    if (obs !== 7'b0011000) begin
      n_fail++;
      $display("FAIL gt_done: got %b want %b", obs, 7'b0011000);
    end
    tick();
    n_chk++;
    if (obs !== 7'b1000000) begin
      n_fail++;
      $display("FAIL gt_ack: got %b want %b", obs, 7'b1000000);
    end
  endtask

  task automatic test_early_decision();
    res_ready = 1'b1;
    run_bits(8'h80, 8'h7F, 7, 0, -1, -1);
    n_chk++;
    if (obs !== 7'b0011000) begin
      n_fail++;
      $display("FAIL early_gt: got %b want %b", obs, 7'b0011000);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    res_ready = 1'b0;
    run_bits(8'h3C, 8'h3C, 7, 0, -1, -1);
    n_chk++;
    if (obs !== 7'b0010010) begin
      n_fail++;
      $display("FAIL eq_done: got %b want %b", obs, 7'b0010010);
    end
    in_valid = 1'b1;
    AsB = 1'b1;
    AiB = 1'b0;
    AeB = 1'b0;
    tick();
    n_chk++;
    if (obs !== 7'b0010010) begin
      n_fail++;
      $display("FAIL eq_no_accept: got %b want %b", obs, 7'b0010010);
    end
    res_ready = 1'b1;
    tick();
    n_chk++;
    if (obs !== 7'b1000000) begin
      n_fail++;
      $display("FAIL eq_ack_no_overlap: got %b want %b", obs, 7'b1000000);
    end
    in_valid = 1'b0;
    run_bits(8'h12, 8'h34, 7, 0, -1, -1);
    n_chk++;
    if (obs !== 7'b0010100) begin
      n_fail++;
      $display("FAIL b2b_lt: got %b want %b", obs, 7'b0010100);
    end
    tick();
  endtask

  task automatic test_code_err();
    res_ready = 1'b1;
    run_bits(8'h5A, 8'h5A, 7, 0, 3, -1);
    n_chk++;
    if (obs !== 7'b0010011) begin
      n_fail++;
      $display("FAIL err_word: got %b want %b", obs, 7'b0010011);
    end
    tick();
    n_chk++;
    if (obs[6:1] !== 6'b100000) begin
      n_fail++;
      $display("FAIL err_ack: got %b want %b", obs[6:1], 6'b100000);
    end
    run_bits(8'h5A, 8'h5A, 7, 0, -1, 4);
    n_chk++;
    if (obs !== 7'b0010010) begin
      n_fail++;
      $display("FAIL err_clean_gap: got %b want %b", obs, 7'b0010010);
    end
    tick();
  endtask

  task automatic test_hold();
    res_ready = 1'b0;
    run_bits(8'hF0, 8'h0F, 7, 0, -1, -1);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      AsB = 1'b0;
      AiB = 1'b1;
      AeB = 1'b0;
      tick();
      n_chk++;
      if (obs !== 7'b0011000) begin
        n_fail++;
        $display("FAIL hold_%0d: got %b want %b", k, obs, 7'b0011000);
      end
    end
    in_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    n_chk++;
    if (obs !== 7'b1000000) begin
      n_fail++;
      $display("FAIL hold_ack: got %b want %b", obs, 7'b1000000);
    end
  endtask

  task automatic test_reset_mid();
    res_ready = 1'b1;
    run_bits(8'h5A, 8'hA5, 7, 4, -1, -1);
    n_chk++;
    if (obs !== 7'b1100000) begin
      n_fail++;
      $display("FAIL mid_busy: got %b want %b", obs, 7'b1100000);
    end
    rst_n = 1'b0;
    tick();
    n_chk++;
    if (obs !== 7'b0000000) begin
      n_fail++;
      $display("FAIL mid_reset: got %b want %b", obs, 7'b0000000);
    end
    rst_n = 1'b1;
    repeat (3) tick();
    n_chk++;
    if (obs !== 7'b1000000) begin
      n_fail++;
      $display("FAIL mid_no_result: got %b want %b", obs, 7'b1000000);
    end
    run_bits(8'h01, 8'h02, 7, 0, -1, -1);
    n_chk++;
    if (obs !== 7'b0010100) begin
      n_fail++;
      $display("FAIL mid_fresh_lt: got %b want %b", obs, 7'b0010100);
    end
    tick();
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    AsB = 1'b0;
    AiB = 1'b0;
    AeB = 1'b0;
    res_ready = 1'b0;
    n_chk = 0;
    n_fail = 0;
    test_reset();
    test_gt();
    test_early_decision();
    test_back_to_back();
    test_code_err();
    test_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
